// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
//   ctrl_state_e : sequencer phase encoding
//   TRAP_*       : encodings reported on o_trap_cause
//   timer_width  : counter width needed to reach a given wait limit
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } ctrl_state_e;

  localparam logic TRAP_ILLEGAL = 1'b0;
  localparam logic TRAP_TIMEOUT = 1'b1;

  // A limit of 0 (timeout disabled) still gets a 1-bit counter so the
  // timer keeps a legal, constant-width declaration.
  function automatic int unsigned timer_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Bus between the control sequencer and the rest of the core.
//   i_inst_valid, i_rd_wren, i_mem_wren, i_is_load : decode results
//   i_mem_ack                                      : memory completion
//   o_mem_req, o_mem_we, o_mem_addr_sel            : memory port control
//   o_ir_en, o_pc_en, o_rd_wren                    : datapath enables
//   o_retire, o_trap, o_trap_cause, o_retire_cnt   : status
// slave  : sequencer side.  master : core / memory side.
interface multicycle_ctrl_fsm_if;
  logic        i_inst_valid;
  logic        i_rd_wren;
  logic        i_mem_wren;
  logic        i_is_load;
  logic        i_mem_ack;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        o_mem_addr_sel;
  logic        o_ir_en;
  logic        o_pc_en;
  logic        o_rd_wren;
  logic        o_retire;
  logic        o_trap;
  logic        o_trap_cause;
  logic [31:0] o_retire_cnt;

  modport slave (
    input  i_inst_valid, i_rd_wren, i_mem_wren, i_is_load, i_mem_ack,
    output o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_en, o_pc_en,
           o_rd_wren, o_retire, o_trap, o_trap_cause, o_retire_cnt
  );

  modport master (
    output i_inst_valid, i_rd_wren, i_mem_wren, i_is_load, i_mem_ack,
    input  o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_en, o_pc_en,
           o_rd_wren, o_retire, o_trap, o_trap_cause, o_retire_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Wait-cycle counter shared by the fetch and data memory phases.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_clear        : hold the count at zero (outside a request phase)
//   i_count        : one more request cycle without acknowledge
//   o_expired      : count has reached MEM_TIMEOUT (never when MEM_TIMEOUT=0)
module multicycle_ctrl_fsm_mem_wait_timer
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned     CW     = timer_width(MEM_TIMEOUT);
  localparam logic [CW-1:0]   LIMIT  = CW'(MEM_TIMEOUT);
  localparam bit              TMO_EN = (MEM_TIMEOUT != 0);

  logic [CW-1:0] r_cnt;

  // Saturates at the limit: reaching it without an ack ends the request.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                      r_cnt <= '0;
    else if (i_clear)                 r_cnt <= '0;
    else if (i_count && r_cnt != LIMIT) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = TMO_EN && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Phase sequencer for the multi-cycle RV32I core. Steps through
// FETCH/DECODE/EXEC/MEM/WB, sharing one memory port between instruction
// fetch and load/store, and traps on illegal opcodes or memory timeouts.
//   i_clk   : core clock, rising edge
//   i_reset : asynchronous active-high reset (returns to FETCH)
//   bus     : multicycle_ctrl_fsm_if.slave (decode inputs, memory
//             handshake, datapath enables, retire/trap status)
// Parameter MEM_TIMEOUT: max wait cycles per memory request, 0 disables.
// Optional macro RETIRE_CNT_EN: adds the 32-bit retired-instruction
// counter on o_retire_cnt; without it o_retire_cnt is constant zero.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic                  i_clk,
  input logic                  i_reset,
  multicycle_ctrl_fsm_if.slave bus
);

  ctrl_state_e r_state;
  logic        r_trap_cause;

  logic w_in_req_state;
  logic w_req;
  logic w_expired;
  logic w_retire;

  assign w_in_req_state = (r_state == FETCH) || (r_state == MEM);
  // Reset forces FETCH, so the request is masked by reset to let it drop
  // immediately and to keep the aborted fetch from latching the IR.
  assign w_req          = w_in_req_state && !i_reset;
  assign w_retire       = (r_state == WB);

  multicycle_ctrl_fsm_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (!w_in_req_state),
    .i_count   (w_req && !bus.i_mem_ack),
    .o_expired (w_expired)
  );

  // An ack in the expiry cycle takes priority over the timeout.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= FETCH;
      r_trap_cause <= TRAP_ILLEGAL;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.i_mem_ack) begin
            r_state <= DECODE;
          end else if (w_expired) begin
            r_state      <= TRAP;
            r_trap_cause <= TRAP_TIMEOUT;
          end
        end
        DECODE: begin
          if (bus.i_inst_valid) begin
            r_state <= EXEC;
          end else begin
            r_state      <= TRAP;
            r_trap_cause <= TRAP_ILLEGAL;
          end
        end
        EXEC: r_state <= (bus.i_is_load || bus.i_mem_wren) ? MEM : WB;
        MEM: begin
          if (bus.i_mem_ack) begin
            r_state <= WB;
          end else if (w_expired) begin
            r_state      <= TRAP;
            r_trap_cause <= TRAP_TIMEOUT;
          end
        end
        WB:      r_state <= FETCH;
        TRAP:    r_state <= TRAP;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign bus.o_mem_req      = w_req;
  assign bus.o_mem_addr_sel = (r_state == MEM);
  assign bus.o_mem_we       = (r_state == MEM) && bus.i_mem_wren;
  assign bus.o_ir_en        = (r_state == FETCH) && !i_reset && bus.i_mem_ack;
  assign bus.o_pc_en        = w_retire;
  // Stores never write rd, whatever the decoder reports for rd.
  assign bus.o_rd_wren      = w_retire && bus.i_rd_wren && !bus.i_mem_wren;
  assign bus.o_retire       = w_retire;
  assign bus.o_trap         = (r_state == TRAP);
  assign bus.o_trap_cause   = r_trap_cause;

`ifdef RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)       r_retire_cnt <= 32'd0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign bus.o_retire_cnt = r_retire_cnt;
`else
  assign bus.o_retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
  import multicycle_ctrl_fsm_pkg::*;

  localparam int unsigned TMO   = 4;
  localparam int          NEVER = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(
    .MEM_TIMEOUT (TMO)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    bit trap;
    bit cause;
    int end_cyc;
    int ir_cyc;
    int ir_n;
    bit rd;
    int addr_n;
    int we_n;
    int pc_n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   retired  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef RETIRE_CNT_EN
    return 32'(retired);
`else
    return 32'd0;
`endif
  endfunction

  // Expected outcome derived from the phase latencies: fetch takes fw+1
  // cycles, decode and exec one each, a memory phase mw+1, then WB.
  task automatic push_exp(input bit valid, input bit rd, input bit st, input bit ld,
                          input int fw, input int mw);
    exp_t e;
    bit   mem = st | ld;
    e.trap = 0; e.cause = 0; e.rd = 0; e.addr_n = 0; e.we_n = 0; e.pc_n = 0;
    e.ir_cyc = fw; e.ir_n = 1;
    if (fw > int'(TMO)) begin
      e.trap = 1; e.cause = 1; e.end_cyc = int'(TMO) + 1; e.ir_cyc = -1; e.ir_n = 0;
    end else if (!valid) begin
      e.trap = 1; e.cause = 0; e.end_cyc = fw + 2;
    end else if (mem && mw > int'(TMO)) begin
      e.trap = 1; e.cause = 1; e.end_cyc = fw + 3 + int'(TMO) + 1;
      e.addr_n = int'(TMO) + 1; e.we_n = st ? int'(TMO) + 1 : 0;
    end else begin
      e.end_cyc = 3 + fw + (mem ? mw + 1 : 0);
      e.rd      = rd & !st;
      e.addr_n  = mem ? mw + 1 : 0;
      e.we_n    = st ? mw + 1 : 0;
      e.pc_n    = 1;
    end
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_mem_ack = 1'b0; bus.i_inst_valid = 1'b0; bus.i_rd_wren = 1'b0;
    bus.i_mem_wren = 1'b0; bus.i_is_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    retired = 0;
  endtask

  // Runs one instruction starting at its first FETCH cycle. tie=1 holds ack
  // high throughout; otherwise ack comes after fw / mw wait cycles and is
  // driven high whenever no request is pending (it must be ignored).
  task automatic run_instr(input string name, input bit valid, input bit rd, input bit st,
                           input bit ld, input int fw, input int mw, input bit tie);
    exp_t e;
    int   c = 0, reqn = 0, ir_cyc = -1, ir_n = 0, addr_n = 0, we_n = 0, pc_n = 0;
    int   end_cyc = -1;
    bit   done = 0, got_trap = 0, rd_seen = 0, rd_bad = 0;
    push_exp(valid, rd, st, ld, tie ? 0 : fw, tie ? 0 : mw);
    bus.i_inst_valid = valid; bus.i_rd_wren = rd; bus.i_mem_wren = st; bus.i_is_load = ld;
    while (!done && c < 60) begin
      @(negedge clk);
      if (c == 0) chk({name, ".retire_cnt"}, bus.o_retire_cnt, exp_cnt());
      if (tie) bus.i_mem_ack = 1'b1;
      else if (bus.o_mem_req) begin
        bus.i_mem_ack = (reqn == (bus.o_mem_addr_sel ? mw : fw));
        reqn++;
      end else begin
        bus.i_mem_ack = 1'b1;
        reqn = 0;
      end
      #1;
      if (bus.o_ir_en) begin ir_cyc = c; ir_n++; end
      if (bus.o_mem_addr_sel) addr_n++;
      if (bus.o_mem_we) we_n++;
      if (bus.o_pc_en) pc_n++;
      if (bus.o_rd_wren) begin rd_seen = 1; if (!bus.o_retire) rd_bad = 1; end
      if (bus.o_retire) begin done = 1; end_cyc = c; end
      if (bus.o_trap) begin done = 1; got_trap = 1; end_cyc = c; end
      @(posedge clk);
      c++;
    end
    if (!done) chk({name, ".completed"}, 32'd0, 32'd1);
    e = sb.pop_front();
    chk({name, ".trap"},    32'(got_trap), 32'(e.trap));
    chk({name, ".end_cyc"}, 32'(end_cyc),  32'(e.end_cyc));
    chk({name, ".ir_cyc"},  32'(ir_cyc),   32'(e.ir_cyc));
    chk({name, ".ir_n"},    32'(ir_n),     32'(e.ir_n));
    chk({name, ".rd_wren"}, 32'(rd_seen),  32'(e.rd));
    chk({name, ".rd_outside_wb"}, 32'(rd_bad), 32'd0);
    chk({name, ".addr_sel_n"}, 32'(addr_n), 32'(e.addr_n));
    chk({name, ".mem_we_n"},   32'(we_n),   32'(e.we_n));
    chk({name, ".pc_en_n"},    32'(pc_n),   32'(e.pc_n));
    if (got_trap) begin
      chk({name, ".trap_cause"}, 32'(bus.o_trap_cause), 32'(e.cause));
      repeat (4) begin
        @(negedge clk);
        bus.i_mem_ack = 1'b1;
        #1;
        chk({name, ".trap_hold"}, 32'(bus.o_trap), 32'd1);
        chk({name, ".trap_req"},  32'(bus.o_mem_req | bus.o_pc_en | bus.o_ir_en | bus.o_rd_wren), 32'd0);
      end
    end else begin
      retired++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_mem_ack = 1'b1; bus.i_inst_valid = 1'b1; bus.i_rd_wren = 1'b1;
    bus.i_mem_wren = 1'b0; bus.i_is_load = 1'b0;
    #2;
    chk("reset.mem_req",    32'(bus.o_mem_req),    32'd0);
    chk("reset.ir_en",      32'(bus.o_ir_en),      32'd0);
    chk("reset.pc_en",      32'(bus.o_pc_en),      32'd0);
    chk("reset.rd_wren",    32'(bus.o_rd_wren),    32'd0);
    chk("reset.retire",     32'(bus.o_retire),     32'd0);
    chk("reset.trap",       32'(bus.o_trap),       32'd0);
    chk("reset.trap_cause", 32'(bus.o_trap_cause), 32'd0);
    chk("reset.addr_sel",   32'(bus.o_mem_addr_sel | bus.o_mem_we), 32'd0);
    chk("reset.retire_cnt", bus.o_retire_cnt,      32'd0);
    do_reset();

    run_instr("add0", 1, 1, 0, 0, 0, 0, 1);
    run_instr("add1", 1, 1, 0, 0, 0, 0, 1);
    run_instr("add2", 1, 1, 0, 0, 0, 0, 1);
    run_instr("lw_w1_3", 1, 1, 0, 1, 1, 3, 0);
    run_instr("lw_w2_3", 1, 1, 0, 1, 2, 3, 0);
    run_instr("sw_tie", 1, 1, 1, 0, 0, 0, 1);
    run_instr("sw_w0_2", 1, 1, 1, 0, 0, 2, 0);
    run_instr("branch", 1, 0, 0, 0, 1, 0, 0);
    run_instr("fetch_ack_last", 1, 1, 0, 0, int'(TMO), 0, 0);
    run_instr("lw_ack_last", 1, 1, 0, 1, 0, int'(TMO), 0);
    run_instr("illegal", 0, 1, 0, 0, 0, 0, 1);
    do_reset();
    run_instr("fetch_tmo", 1, 1, 0, 0, NEVER, 0, 0);
    do_reset();
    run_instr("add_pre", 1, 1, 0, 0, 0, 0, 1);
    run_instr("lw_tmo", 1, 1, 0, 1, 0, NEVER, 0);
    do_reset();
    run_instr("add_a", 1, 1, 0, 0, 0, 0, 1);
    run_instr("add_b", 1, 1, 0, 0, 0, 0, 1);

    // Abort a load while its data request is outstanding.
    begin
      bit in_mem = 0;
      bus.i_inst_valid = 1; bus.i_rd_wren = 1; bus.i_mem_wren = 0; bus.i_is_load = 1;
      for (int i = 0; i < 20 && !in_mem; i++) begin
        @(negedge clk);
        bus.i_mem_ack = bus.o_mem_req && !bus.o_mem_addr_sel;
        #1;
        if (bus.o_mem_addr_sel) in_mem = 1;
      end
      chk("abort.reached_mem", 32'(in_mem), 32'd1);
      chk("abort.req_before", 32'(bus.o_mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort.req_drop", 32'(bus.o_mem_req), 32'd0);
      chk("abort.enables",  32'(bus.o_pc_en | bus.o_ir_en | bus.o_rd_wren | bus.o_retire), 32'd0);
      chk("abort.cnt_clear", bus.o_retire_cnt, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      retired = 0;
      @(negedge clk);
      bus.i_mem_ack = 1'b0;
      #1;
      chk("abort.fetch_req", 32'(bus.o_mem_req), 32'd1);
      chk("abort.fetch_sel", 32'(bus.o_mem_addr_sel), 32'd0);
      chk("abort.retire_cnt", bus.o_retire_cnt, 32'd0);
    end
    do_reset();
    run_instr("add_after", 1, 1, 0, 0, 0, 0, 1);
    run_instr("add_after2", 1, 0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
